// File: rtl/sync_fifo_ctrl_if.sv
// Handshake/bus bundle between a FIFO user (master) and sync_fifo_ctrl (slave).
interface sync_fifo_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  prog_full;
  logic                  prog_empty;
  logic [ADDR_WIDTH:0]   data_count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           prog_full, prog_empty, data_count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           prog_full, prog_empty, data_count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with standard / FWFT read modes, occupancy count and
// almost/programmable flags. Optional sticky overflow/underflow flags are
// built when SYNC_FIFO_ERR_FLAGS_EN is defined; otherwise they read as 0.
module sync_fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH        = 8,
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned FWFT_EN           = 0,
  parameter int unsigned PROG_FULL_THRESH  = (1 << ADDR_WIDTH) - 4,
  parameter int unsigned PROG_EMPTY_THRESH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  sync_fifo_ctrl_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned PW    = ADDR_WIDTH + 1;

  // Reject illegal threshold settings at elaboration
  if (PROG_FULL_THRESH < 1 || PROG_FULL_THRESH > DEPTH) begin : g_bad_pf
    $error("sync_fifo_ctrl: PROG_FULL_THRESH must be in 1..DEPTH");
  end
  if (PROG_EMPTY_THRESH > DEPTH - 1) begin : g_bad_pe
    $error("sync_fifo_ctrl: PROG_EMPTY_THRESH must be in 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         count_q,  count_d;
  logic                  empty, full;
  logic                  wr_acc, rd_acc;

  // Flags decode the registered count so they line up with data_count
  assign empty                = (count_q == '0);
  assign full                 = (count_q == PW'(DEPTH));
  assign bus.empty            = empty;
  assign bus.full             = full;
  assign bus.almost_full      = (count_q >= PW'(DEPTH - 1));
  assign bus.almost_empty     = (count_q <= PW'(1));
  assign bus.prog_full        = (count_q >= PW'(PROG_FULL_THRESH));
  assign bus.prog_empty       = (count_q <= PW'(PROG_EMPTY_THRESH));
  assign bus.data_count       = count_q;

  // A read frees a slot, so a write into a full FIFO is taken alongside it
  assign rd_acc = bus.rd_en & ~empty;
  assign wr_acc = bus.wr_en & (~full | rd_acc);

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents survive reset, writes during reset are dropped
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.wr_data;
  end

  if (FWFT_EN != 0) begin : g_fwft
    // Head word is presented directly from the array while not empty
    assign bus.rd_data  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    assign bus.rd_valid = ~empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    // Popped word is captured and held until the next pop
    always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_acc;
      if (rd_acc) rd_data_d = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    end

    // Read output registers
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q,  overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error accumulation: rejected writes and reads of an empty FIFO
  always_comb begin
    overflow_d  = overflow_q  | (bus.wr_en & ~wr_acc);
    underflow_d = underflow_q | (bus.rd_en & empty);
  end

  // Error flag registers, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

endmodule
